// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer for the 8-bit bus CPU.
// A 3-bit T counter (T1..T6) plus a halted flag; every bus enable and
// register load strobe is a combinational decode of T-state, opcode,
// halted and rst. Fetch (T1..T3) ignores the opcode; execute (T4..T6)
// decodes the IR high nibble. HLT_OPCODE freezes the sequencer at T4
// until reset.
// Optional build macro: SINGLE_STEP_EN adds a 'step' input that gates
// T-state advance and suppresses pc_inc and all load strobes in cycles
// where step is low.
module control_sequencer #(
    parameter logic [3:0] HLT_OPCODE = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load_n,
    output logic       mar_load_n,
    output logic       ram_out,
    output logic       ir_load_n,
    output logic       ir_out,
    output logic       a_load_n,
    output logic       a_out,
    output logic       b_load_n,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load_n,
    output logic [2:0] t_state,
    output logic       halted
);

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;

    tstate_e state_r;
    tstate_e state_next_s;
    logic    halted_r;
    logic    halted_next_s;
    logic    advance_s;

`ifdef SINGLE_STEP_EN
    assign advance_s = step;
`else
    assign advance_s = 1'b1;
`endif

    assign t_state = state_r;
    assign halted  = halted_r;

    // T-state and halted flag registers; reset returns to T1, running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= T1;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            halted_r <= halted_next_s;
        end
    end

    // Next-state: step T1..T6 with wrap; HLT in T4 latches halted and holds T4.
    always_comb begin
        state_next_s  = state_r;
        halted_next_s = halted_r;
        if (halted_r) begin
            state_next_s  = state_r;
            halted_next_s = 1'b1;
        end else if (advance_s) begin
            if ((state_r == T4) && (opcode == HLT_OPCODE)) begin
                state_next_s  = T4;
                halted_next_s = 1'b1;
            end else begin
                case (state_r)
                    T1:      state_next_s = T2;
                    T2:      state_next_s = T3;
                    T3:      state_next_s = T4;
                    T4:      state_next_s = T5;
                    T5:      state_next_s = T6;
                    T6:      state_next_s = T1;
                    default: state_next_s = T1;
                endcase
            end
        end else begin
            state_next_s  = state_r;
            halted_next_s = halted_r;
        end
    end

    // Control decode: inactive while reset or halted, otherwise fetch/execute microcode.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_load_n  = 1'b1;
        mar_load_n = 1'b1;
        ram_out    = 1'b0;
        ir_load_n  = 1'b1;
        ir_out     = 1'b0;
        a_load_n   = 1'b1;
        a_out      = 1'b0;
        b_load_n   = 1'b1;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        out_load_n = 1'b1;
        if (rst || halted_r) begin
            pc_out = 1'b0;
        end else begin
            case (state_r)
                T1: begin
                    pc_out     = 1'b1;
                    mar_load_n = 1'b0;
                end
                T2: begin
                    pc_inc = 1'b1;
                end
                T3: begin
                    ram_out   = 1'b1;
                    ir_load_n = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_out     = 1'b1;
                            mar_load_n = 1'b0;
                        end
                        OP_LDI: begin
                            ir_out   = 1'b1;
                            a_load_n = 1'b0;
                        end
                        OP_JMP: begin
                            ir_out    = 1'b1;
                            pc_load_n = 1'b0;
                        end
                        OP_OUT: begin
                            a_out      = 1'b1;
                            out_load_n = 1'b0;
                        end
                        default: begin
                            ir_out = 1'b0;
                        end
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out  = 1'b1;
                            a_load_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out  = 1'b1;
                            b_load_n = 1'b0;
                            alu_sub  = (opcode == OP_SUB);
                        end
                        default: begin
                            ram_out = 1'b0;
                        end
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            alu_out  = 1'b1;
                            a_load_n = 1'b0;
                            alu_sub  = (opcode == OP_SUB);
                        end
                        default: begin
                            alu_out = 1'b0;
                        end
                    endcase
                end
                default: begin
                    pc_out = 1'b0;
                end
            endcase
        end
`ifdef SINGLE_STEP_EN
        // Without a step pulse nothing may be written; bus drivers stay visible.
        if (!step) begin
            pc_inc     = 1'b0;
            pc_load_n  = 1'b1;
            mar_load_n = 1'b1;
            ir_load_n  = 1'b1;
            a_load_n   = 1'b1;
            b_load_n   = 1'b1;
            out_load_n = 1'b1;
        end else begin
            pc_inc = pc_inc;
        end
`endif
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table-driven reference model
// (T counter as an integer, halted as a bit, controls from a microcode table)
// is compared every cycle against the DUT.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ir_load_n;
    logic       ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub, out_load_n;
    logic [2:0] t_state;
    logic       halted;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_t;
    bit m_halted;

    // control vector bit positions
    localparam int B_PC_OUT = 12, B_PC_INC = 11, B_PC_LD = 10, B_MAR_LD = 9;
    localparam int B_RAM_OUT = 8, B_IR_LD = 7, B_IR_OUT = 6, B_A_LD = 5;
    localparam int B_A_OUT = 4, B_B_LD = 3, B_ALU_OUT = 2, B_ALU_SUB = 1, B_OUT_LD = 0;
    localparam logic [12:0] NEG_MASK = 13'b0011010101001;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .opcode     (opcode),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .pc_load_n  (pc_load_n),
        .mar_load_n (mar_load_n),
        .ram_out    (ram_out),
        .ir_load_n  (ir_load_n),
        .ir_out     (ir_out),
        .a_load_n   (a_load_n),
        .a_out      (a_out),
        .b_load_n   (b_load_n),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .out_load_n (out_load_n),
        .t_state    (t_state),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Expected controls from the instruction table: list active functions, then polarize.
    function automatic logic [12:0] exp_ctrl(int t, logic [3:0] op, bit h, bit r);
        logic [12:0] act;
        act = 13'd0;
        if (!r && !h) begin
            if (t == 1) begin act[B_PC_OUT] = 1'b1; act[B_MAR_LD] = 1'b1; end
            if (t == 2) act[B_PC_INC] = 1'b1;
            if (t == 3) begin act[B_RAM_OUT] = 1'b1; act[B_IR_LD] = 1'b1; end
            if (t == 4) begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin act[B_IR_OUT] = 1'b1; act[B_MAR_LD] = 1'b1; end
                if (op == 4'h3) begin act[B_IR_OUT] = 1'b1; act[B_A_LD] = 1'b1; end
                if (op == 4'h4) begin act[B_IR_OUT] = 1'b1; act[B_PC_LD] = 1'b1; end
                if (op == 4'hE) begin act[B_A_OUT] = 1'b1; act[B_OUT_LD] = 1'b1; end
            end
            if (t == 5) begin
                if (op == 4'h0) begin act[B_RAM_OUT] = 1'b1; act[B_A_LD] = 1'b1; end
                if (op == 4'h1 || op == 4'h2) begin
                    act[B_RAM_OUT] = 1'b1; act[B_B_LD] = 1'b1; act[B_ALU_SUB] = (op == 4'h2);
                end
            end
            if (t == 6 && (op == 4'h1 || op == 4'h2)) begin
                act[B_ALU_OUT] = 1'b1; act[B_A_LD] = 1'b1; act[B_ALU_SUB] = (op == 4'h2);
            end
        end
        return act ^ NEG_MASK;
    endfunction

    function automatic logic [12:0] obs_ctrl();
        return {pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ir_load_n,
                ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub, out_load_n};
    endfunction

    // Compare DUT against model for the current cycle.
    task automatic check_all(string tag);
        logic [12:0] exp_c;
        logic [12:0] got_c;
        logic [2:0]  exp_t;
        int          drivers;
        exp_c = exp_ctrl(m_t, opcode, m_halted, rst);
        got_c = obs_ctrl();
        exp_t = 3'(m_t);
        checks++;
        assert (got_c === exp_c) else begin
            errors++;
            $error("FAIL %s ctrl: got %b expected %b (t=%0d op=%h)", tag, got_c, exp_c, m_t, opcode);
        end
        checks++;
        assert (t_state === exp_t) else begin
            errors++;
            $error("FAIL %s t_state: got %0d expected %0d", tag, t_state, exp_t);
        end
        checks++;
        assert (halted === m_halted) else begin
            errors++;
            $error("FAIL %s halted: got %b expected %b", tag, halted, m_halted);
        end
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        checks++;
        assert (drivers <= 1) else begin
            errors++;
            $error("FAIL %s bus_excl: got %0d drivers expected at most 1", tag, drivers);
        end
    endtask

    // Advance one clock; the model steps on the rising edge using the applied opcode.
    task automatic tick();
        @(posedge clk);
        if (!rst && !m_halted) begin
            if (m_t == 4 && opcode == 4'hF) m_halted = 1'b1;
            else m_t = (m_t == 6) ? 1 : m_t + 1;
        end
        @(negedge clk);
    endtask

    // Run one instruction from T1; optionally scramble opcode during fetch.
    task automatic run_instr(logic [3:0] op, bit rand_fetch, string tag);
        for (int ph = 0; ph < 3; ph++) begin
            opcode = rand_fetch ? 4'($urandom) : op;
            #1 check_all(tag);
            tick();
        end
        opcode = op;
        for (int ph = 0; ph < 3; ph++) begin
            #1 check_all(tag);
            tick();
        end
    endtask

    initial begin
        logic [3:0] rop;
        rst    = 1'b1;
        opcode = 4'h0;
        m_t    = 1;
        m_halted = 1'b0;
`ifdef SINGLE_STEP_EN
        step   = 1'b1;
`endif
        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_all("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        // directed instructions, including explicit NOP 0101
        run_instr(4'h1, 1'b0, "add");
        run_instr(4'h2, 1'b0, "sub");
        run_instr(4'h0, 1'b0, "lda");
        run_instr(4'h3, 1'b0, "ldi");
        run_instr(4'h4, 1'b0, "jmp");
        run_instr(4'hE, 1'b0, "out");
        run_instr(4'h5, 1'b0, "nop");
        run_instr(4'h1, 1'b1, "add_fetchnoise");

        // reset asserted mid-T5 of LDA, checked before any clock edge
        opcode = 4'h0;
        for (int ph = 0; ph < 4; ph++) begin
            #1 check_all("lda_pre");
            tick();
        end
        #1 check_all("lda_t5");
        checks++;
        assert ({ram_out, a_load_n} === 2'b10) else begin
            errors++;
            $error("FAIL lda_t5_strobes: got %b expected 10", {ram_out, a_load_n});
        end
        rst = 1'b1;
        m_t = 1;
        m_halted = 1'b0;
        #1 check_all("async_rst");
        @(negedge clk);
        #1 check_all("async_rst_hold");
        rst = 1'b0;
        run_instr(4'h0, 1'b0, "after_rst");

        // randomized instruction stream, HLT excluded
        for (int n = 0; n < 1000; n++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr(rop, 1'b1, "random");
        end

        // HLT: frozen at T4 with controls inactive
        run_instr(4'hF, 1'b0, "hlt");
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom);
            #1 check_all("halted");
            tick();
        end
        rst = 1'b1;
        m_t = 1;
        m_halted = 1'b0;
        #1 check_all("hlt_rst");
        @(negedge clk);
        rst = 1'b0;
        run_instr(4'h2, 1'b0, "post_hlt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
